// File: rtl/dmem_responder.sv
// Single-port data memory responder for an RV32I core: one request in flight, IDLE -> ACCESS -> RESP.
// Define DMEM_MISALIGN_ERR_EN to reject misaligned half/word accesses instead of force-aligning them.
module dmem_responder #(
  parameter int ADDR_BITS = 6
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [2:0]  req_funct3,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t               state_q;
  logic                 we_q;
  logic [ADDR_BITS+1:0] addr_q;
  logic [31:0]          wdata_q;
  logic [2:0]           funct3_q;
  logic [31:0]          rdata_q;
  logic                 err_q;

  logic [31:0] mem [2**ADDR_BITS];

  logic [ADDR_BITS-1:0] idx_d;
  logic [1:0]           off_d;
  logic                 bad_d;
  logic [3:0]           be_d;
  logic [31:0]          wshift_d;
  logic [31:0]          rdata_d;
  logic [31:0]          word_d;
  logic [31:0]          bytesh_d;
  logic [15:0]          half_d;

  // Upper address bits wrap modulo the memory depth.
  logic unused_addr;
  assign unused_addr = ^req_addr[31:ADDR_BITS+2];

  assign req_ready = (state_q == IDLE);
  assign rsp_valid = (state_q == RESP);
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;

  always_comb begin
    idx_d    = addr_q[ADDR_BITS+1:2];
    word_d   = mem[idx_d];
    off_d    = addr_q[1:0];
    bad_d    = 1'b0;
    be_d     = 4'b0000;
    wshift_d = '0;
    rdata_d  = '0;
    bytesh_d = '0;
    half_d   = '0;

    case (funct3_q[1:0])
      2'b01: begin
`ifdef DMEM_MISALIGN_ERR_EN
        if (addr_q[0]) bad_d = 1'b1;
`else
        off_d[0] = 1'b0;
`endif
      end
      2'b10: begin
`ifdef DMEM_MISALIGN_ERR_EN
        if (addr_q[1:0] != 2'b00) bad_d = 1'b1;
`else
        off_d = 2'b00;
`endif
      end
      2'b11:   bad_d = 1'b1;
      default: ;
    endcase
    // Only LBU/LHU use funct3[2]; every store with it set is illegal.
    if (funct3_q[2] && (we_q || funct3_q[1])) bad_d = 1'b1;

    if (!bad_d) begin
      if (we_q) begin
        case (funct3_q[1:0])
          2'b00: begin
            be_d     = 4'b0001 << off_d;
            wshift_d = {4{wdata_q[7:0]}};
          end
          2'b01: begin
            be_d     = 4'b0011 << off_d;
            wshift_d = {2{wdata_q[15:0]}};
          end
          default: begin
            be_d     = 4'b1111;
            wshift_d = wdata_q;
          end
        endcase
      end else begin
        bytesh_d = word_d >> {off_d, 3'b000};
        half_d   = off_d[1] ? word_d[31:16] : word_d[15:0];
        case (funct3_q[1:0])
          2'b00:   rdata_d = funct3_q[2] ? {24'b0, bytesh_d[7:0]}
                                         : {{24{bytesh_d[7]}}, bytesh_d[7:0]};
          2'b01:   rdata_d = funct3_q[2] ? {16'b0, half_d}
                                         : {{16{half_d[15]}}, half_d};
          default: rdata_d = word_d;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      funct3_q <= '0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_valid) begin
            we_q     <= req_we;
            addr_q   <= req_addr[ADDR_BITS+1:0];
            wdata_q  <= req_wdata;
            funct3_q <= req_funct3;
            state_q  <= ACCESS;
          end
        end
        ACCESS: begin
          rdata_q <= rdata_d;
          err_q   <= bad_d;
          state_q <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            rdata_q <= '0;
            err_q   <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // No reset on the array; a reset during ACCESS has already forced IDLE, so nothing is written.
  always_ff @(posedge clk) begin
    if (rst_n && state_q == ACCESS) begin
      for (int b = 0; b < 4; b++) begin
        if (be_d[b]) mem[idx_d][8*b +: 8] <= wshift_d[8*b +: 8];
      end
    end
  end

endmodule
